pe_result_collector: RTL and testbench

Downstream stage of the PEran processing element. Accepts each 32-bit `final_result` word (16 mutated nucleotides, 2 bits each) over a valid/ready handshake and buffers it in a small FIFO for the output/host side. While buffering, it keeps running per-base counts (A/C/G/T). Every `FRAME_WORDS` accepted words it latches a snapshot of those counts for the statistics/readback path.

---
 rtl/pe_result_collector.sv | 165 ++++++++++++++++
 tb/tb_pe_result_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// Output stage of the PEran processing element: buffers final_result words in a FIFO
// and keeps running A/C/G/T counts with a snapshot latched at every frame boundary.
module pe_result_collector #(
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_c,
    output logic [CNT_W-1:0] count_g,
    output logic [CNT_W-1:0] count_t,
    output logic [CNT_W-1:0] words_total,
    output logic [CNT_W-1:0] snap_a,
    output logic [CNT_W-1:0] snap_c,
    output logic [CNT_W-1:0] snap_g,
    output logic [CNT_W-1:0] snap_t,
    output logic             frame_done,
    output logic             sat
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = CNT_W + 6;
    localparam logic [AW:0]      DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [SW-1:0]    MAX_S     = {6'd0, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_WORDS - 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          accept;
    logic          pop;

    // Handshake flags depend only on registered occupancy, never on the partner's strobe.
    assign in_ready  = (occ < DEPTH_L);
    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    logic [4:0] wc_a, wc_c, wc_g, wc_t;

    always_comb begin
        wc_a = '0;
        wc_c = '0;
        wc_g = '0;
        wc_t = '0;
        for (int i = 0; i < 16; i++) begin
            case (in_data[2*i +: 2])
                2'b00:   wc_a = wc_a + 5'd1;
                2'b01:   wc_c = wc_c + 5'd1;
                2'b10:   wc_g = wc_g + 5'd1;
                default: wc_t = wc_t + 5'd1;
            endcase
        end
    end

    // Returns {overflow, clamped sum}.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] base, input logic [4:0] inc);
        logic [SW-1:0] s;
        s = {6'd0, base} + {{(CNT_W+1){1'b0}}, inc};
        if (s > MAX_S) sat_add = {1'b1, {CNT_W{1'b1}}};
        else           sat_add = {1'b0, s[CNT_W-1:0]};
    endfunction

    // A clear in the same cycle as an accept zeroes the base, so the word still counts.
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] base_a, base_c, base_g, base_t, base_w, frame_base;
    logic             sat_base;
    logic [CNT_W:0]   nx_a, nx_c, nx_g, nx_t, nx_w;
    logic             frame_end;

    always_comb begin
        base_a     = clear_counts ? '0 : count_a;
        base_c     = clear_counts ? '0 : count_c;
        base_g     = clear_counts ? '0 : count_g;
        base_t     = clear_counts ? '0 : count_t;
        base_w     = clear_counts ? '0 : words_total;
        frame_base = clear_counts ? '0 : frame_cnt;
        sat_base   = clear_counts ? 1'b0 : sat;
        nx_a       = sat_add(base_a, wc_a);
        nx_c       = sat_add(base_c, wc_c);
        nx_g       = sat_add(base_g, wc_g);
        nx_t       = sat_add(base_t, wc_t);
        nx_w       = sat_add(base_w, 5'd1);
        frame_end  = (frame_base == FRAME_END);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_a     <= '0;
            count_c     <= '0;
            count_g     <= '0;
            count_t     <= '0;
            words_total <= '0;
            frame_cnt   <= '0;
            snap_a      <= '0;
            snap_c      <= '0;
            snap_g      <= '0;
            snap_t      <= '0;
            frame_done  <= 1'b0;
            sat         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                count_a     <= nx_a[CNT_W-1:0];
                count_c     <= nx_c[CNT_W-1:0];
                count_g     <= nx_g[CNT_W-1:0];
                count_t     <= nx_t[CNT_W-1:0];
                words_total <= nx_w[CNT_W-1:0];
                sat         <= sat_base | nx_a[CNT_W] | nx_c[CNT_W] | nx_g[CNT_W]
                                        | nx_t[CNT_W] | nx_w[CNT_W];
                if (frame_end) begin
                    frame_cnt  <= '0;
                    snap_a     <= nx_a[CNT_W-1:0];
                    snap_c     <= nx_c[CNT_W-1:0];
                    snap_g     <= nx_g[CNT_W-1:0];
                    snap_t     <= nx_t[CNT_W-1:0];
                    frame_done <= 1'b1;
                end else begin
                    frame_cnt <= frame_base + 1'b1;
                end
            end else if (clear_counts) begin
                count_a     <= '0;
                count_c     <= '0;
                count_g     <= '0;
                count_t     <= '0;
                words_total <= '0;
                frame_cnt   <= '0;
                sat         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_result_collector.sv
// Self-checking bench for pe_result_collector: a default instance for FIFO/frame
// behaviour and a CNT_W=5 instance for saturation, with a queue scoreboard on the FIFO.
module tb_pe_result_collector;
    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, clear_counts;
    logic [31:0] in_data, out_data;
    logic [15:0] count_a, count_c, count_g, count_t, words_total;
    logic [15:0] snap_a, snap_c, snap_g, snap_t;
    logic        frame_done, sat;

    logic        s_in_valid, s_in_ready, s_out_valid, s_clear;
    logic [31:0] s_in_data, s_out_data;
    logic [4:0]  s_count_a, s_count_c, s_count_g, s_count_t, s_words_total;
    logic [4:0]  s_snap_a, s_snap_c, s_snap_g, s_snap_t;
    logic        s_frame_done, s_sat;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q[$];

    pe_result_collector #(.DEPTH(8), .CNT_W(16), .FRAME_WORDS(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .clear_counts(clear_counts),
        .count_a(count_a), .count_c(count_c), .count_g(count_g), .count_t(count_t),
        .words_total(words_total),
        .snap_a(snap_a), .snap_c(snap_c), .snap_g(snap_g), .snap_t(snap_t),
        .frame_done(frame_done), .sat(sat)
    );

    pe_result_collector #(.DEPTH(8), .CNT_W(5), .FRAME_WORDS(4)) u_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(1'b1),
        .clear_counts(s_clear),
        .count_a(s_count_a), .count_c(s_count_c), .count_g(s_count_g), .count_t(s_count_t),
        .words_total(s_words_total),
        .snap_a(s_snap_a), .snap_c(s_snap_c), .snap_g(s_snap_g), .snap_t(s_snap_t),
        .frame_done(s_frame_done), .sat(s_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: words enter the queue on accept and are checked in order on pop.
    always @(posedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_underflow: got %h want no pop", out_data);
                end else begin
                    if (out_data !== exp_q[0])
                        $display("FAIL pop_order: got %h want %h", out_data, exp_q[0]);
                    else
                        pass_cnt++;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    function automatic int base_count(input logic [31:0] w, input logic [1:0] code);
        int n = 0;
        for (int i = 0; i < 16; i++) if (w[2*i +: 2] == code) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if ({count_a, count_c, count_g, count_t} !== 64'd0) $display("FAIL rst_counts: got %h want 0", {count_a, count_c, count_g, count_t}); else pass_cnt++;
        total_cnt++; if ({snap_a, snap_c, snap_g, snap_t} !== 64'd0) $display("FAIL rst_snaps: got %h want 0", {snap_a, snap_c, snap_g, snap_t}); else pass_cnt++;
        total_cnt++; if ({words_total, frame_done, sat} !== 18'd0) $display("FAIL rst_misc: got %h want 0", {words_total, frame_done, sat}); else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'h51652D55; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (count_a !== 16'd2) $display("FAIL single_a: got %0d want 2", count_a); else pass_cnt++;
        total_cnt++; if (count_c !== 16'd11) $display("FAIL single_c: got %0d want 11", count_c); else pass_cnt++;
        total_cnt++; if (count_g !== 16'd2) $display("FAIL single_g: got %0d want 2", count_g); else pass_cnt++;
        total_cnt++; if (count_t !== 16'd1) $display("FAIL single_t: got %0d want 1", count_t); else pass_cnt++;
        total_cnt++; if (words_total !== 16'd1) $display("FAIL single_words: got %0d want 1", words_total); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h51652D55) $display("FAIL single_out_data: got %h want 51652d55", out_data); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_frame();
        logic [31:0] words [4];
        words[0] = 32'h00000000; words[1] = 32'hFFFFFFFF;
        words[2] = 32'hAAAAAAAA; words[3] = 32'h55555555;
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = words[i];
            tick();
            total_cnt++; if (frame_done !== (i == 3)) $display("FAIL frame_done_%0d: got %b want %b", i, frame_done, (i == 3)); else pass_cnt++;
        end
        in_valid = 1'b0;
        total_cnt++; if ({snap_a, snap_c, snap_g, snap_t} !== {4{16'd16}}) $display("FAIL frame_snaps: got %h want 0010001000100010", {snap_a, snap_c, snap_g, snap_t}); else pass_cnt++;
        total_cnt++; if (words_total !== 16'd4) $display("FAIL frame_words: got %0d want 4", words_total); else pass_cnt++;
        tick();
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL frame_done_pulse: got %b want 0", frame_done); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 32'hF0000000 | 32'(i);
            tick();
            total_cnt++; if (in_ready !== (i < 7)) $display("FAIL full_in_ready_%0d: got %b want %b", i, in_ready, (i < 7)); else pass_cnt++;
        end
        in_valid = 1'b0;
        total_cnt++; if (words_total !== 16'd12) $display("FAIL full_words: got %0d want 12", words_total); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++; if (out_valid !== (i < 7)) $display("FAIL full_out_valid_%0d: got %b want %b", i, out_valid, (i < 7)); else pass_cnt++;
        end
        out_ready = 1'b0;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL full_drain: got %0d left want 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int exp_g = 0;
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        for (int i = 0; i < 23; i++) begin
            in_valid = 1'b1; in_data = $urandom;
            out_ready = (i >= 3);
            exp_g += base_count(in_data, 2'b10);
            tick();
            if (i >= 3) begin
                total_cnt++; if ({in_ready, out_valid} !== 2'b11) $display("FAIL b2b_flags_%0d: got %b want 11", i, {in_ready, out_valid}); else pass_cnt++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_occ3: got %b want 1", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", out_valid); else pass_cnt++;
        out_ready = 1'b0;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); else pass_cnt++;
        total_cnt++; if (count_g !== 16'(exp_g)) $display("FAIL b2b_count_g: got %0d want %0d", count_g, exp_g); else pass_cnt++;
        total_cnt++; if (words_total !== 16'd23) $display("FAIL b2b_words: got %0d want 23", words_total); else pass_cnt++;
    endtask

    task automatic test_saturate();
        s_in_valid = 1'b1; s_in_data = 32'h0;
        tick();
        total_cnt++; if ({s_count_a, s_sat} !== {5'd16, 1'b0}) $display("FAIL sat_first: got a=%0d sat=%b want a=16 sat=0", s_count_a, s_sat); else pass_cnt++;
        tick();
        total_cnt++; if ({s_count_a, s_sat} !== {5'd31, 1'b1}) $display("FAIL sat_second: got a=%0d sat=%b want a=31 sat=1", s_count_a, s_sat); else pass_cnt++;
        tick(); tick();
        total_cnt++; if ({s_frame_done, s_snap_a, s_words_total} !== {1'b1, 5'd31, 5'd4}) $display("FAIL sat_frame: got fd=%b snap_a=%0d words=%0d want 1/31/4", s_frame_done, s_snap_a, s_words_total); else pass_cnt++;
        s_in_valid = 1'b0; s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        total_cnt++; if ({s_count_a, s_sat, s_words_total} !== 11'd0) $display("FAIL sat_clear: got a=%0d sat=%b words=%0d want 0", s_count_a, s_sat, s_words_total); else pass_cnt++;
        total_cnt++; if (s_snap_a !== 5'd31) $display("FAIL sat_snap_keep: got %0d want 31", s_snap_a); else pass_cnt++;
        s_clear = 1'b1; s_in_valid = 1'b1; s_in_data = 32'hFFFFFFFF;
        tick();
        s_clear = 1'b0; s_in_valid = 1'b0;
        total_cnt++; if ({s_count_a, s_count_t, s_words_total, s_sat} !== {5'd0, 5'd16, 5'd1, 1'b0}) $display("FAIL sat_clear_accept: got a=%0d t=%0d words=%0d sat=%b want 0/16/1/0", s_count_a, s_count_t, s_words_total, s_sat); else pass_cnt++;
    endtask

    task automatic test_reset_midburst();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'hC0DE0000 | 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL mid_flags: got %b want 01", {out_valid, in_ready}); else pass_cnt++;
        total_cnt++; if ({count_a, count_c, count_g, count_t, words_total} !== 80'd0) $display("FAIL mid_counts: got %h want 0", {count_a, count_c, count_g, count_t, words_total}); else pass_cnt++;
        total_cnt++; if (s_count_t !== 5'd0) $display("FAIL mid_sat_counts: got %0d want 0", s_count_t); else pass_cnt++;
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_counts = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_clear = 1'b0;
        #2;
        test_reset();
        test_single();
        test_frame();
        test_full();
        test_back_to_back();
        test_saturate();
        test_reset_midburst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
